eip_redirect_ctrl: RTL and testbench
====================================

EIP_REDIRECT_CTRL -- requirements
Module: eip_redirect_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, flush pulse length in cycles, legal range 1..15.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'hFFFF_FFF0, EIP value after reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 de_valid  in  1  decode slot valid and not stalled; sequential advance request.
REQ-006 de_eip_next  in  32  sequential next EIP from decode.
REQ-007 wb_redir_req  in  1  writeback taken branch / EIP change.
REQ-008 wb_redir_target  in  32  writeback redirect target.
REQ-009 exc_req  in  1  exception/interrupt redirect request; level, held until exc_ack.
REQ-010 exc_vector  in  32  exception handler address.
REQ-011 fe_ready  in  1  fetch accepts the redirect target.
REQ-012 r_eip  out  32  architectural EIP register.
REQ-013 flush  out  1  pipeline flush, decode and fetch latches.
REQ-014 fe_redirect  out  1  fetch redirect valid; target is r_eip.
REQ-015 exc_ack  out  1  one-cycle acknowledge of exc_req.
REQ-016 busy  out  1  high whenever state is not RUN.
REQ-017 perf_redir_cnt  out  16  redirect count (present only with macro, REQ-038).

Function
REQ-018 SHALL implement FSM states RUN, FLUSH and REFILL.
REQ-019 RUN, priority exc_req > wb_redir_req > de_valid, one action per cycle.
REQ-020 RUN + exc_req: r_eip <= exc_vector, exc_ack=1 that cycle, go to FLUSH.
REQ-021 RUN + wb_redir_req (no exc_req): r_eip <= wb_redir_target, go to FLUSH.
REQ-022 RUN + de_valid only: r_eip <= de_eip_next, stay in RUN; no request: r_eip holds.
REQ-023 FLUSH: flush=1 for exactly FLUSH_CYCLES consecutive cycles, then go to REFILL.
REQ-024 REFILL: fe_redirect=1 until fe_ready sampled high, then go to RUN on the next edge.
REQ-025 REFILL + fe_ready in the same cycle as entry: one-cycle fe_redirect pulse, then RUN.
REQ-026 FLUSH/REFILL: de_valid and wb_redir_req are ignored, as younger work is being flushed.
REQ-027 FLUSH/REFILL + exc_req: r_eip <= exc_vector, exc_ack=1, restart FLUSH with full count.
REQ-028 exc_ack SHALL never be high for two consecutive cycles.
REQ-029 r_eip loads complete in one cycle: the new value is visible on the edge after acceptance.
REQ-030 Targets are used unmodified at full 32 bits; there is no alignment or truncation.
REQ-031 flush, fe_redirect and busy SHALL be registered outputs with no combinational input-to-output path; exc_ack is the only combinational output.

Reset
REQ-032 rst SHALL set state=RUN, r_eip=RESET_VECTOR, flush=0, fe_redirect=0, busy=0 and clear the flush counter.
REQ-033 rst has priority over all requests and takes effect on the next edge.
REQ-034 exc_ack is 0 while rst is high.
REQ-035 Reset during FLUSH or REFILL SHALL abandon the redirect with no further flush or fe_redirect cycles.

Configuration
REQ-036 Macro EIP_REDIR_PERF_EN controls perf_redir_cnt.
REQ-037 Without the macro, the perf_redir_cnt port and its logic are absent.
REQ-038 With the macro, the 16-bit counter increments on each accepted exc or wb redirect, saturates at 16'hFFFF, and resets to 0.

Structure
REQ-039 Package eip_ctrl_pkg SHALL hold the state enum (RUN/FLUSH/REFILL), the default RESET_VECTOR and the 4-bit flush-count width.
REQ-040 Sub-module eip_flush_timer SHALL be a loadable 4-bit down-counter with a done flag, used by FLUSH.

Verification
REQ-041 rst, then de_valid=1 with de_eip_next=32'h0000_1004 -> r_eip=FFFF_FFF0 after reset, 0000_1004 one cycle later, busy=0.
REQ-042 RUN, wb_redir_req=1 with target 32'h0000_2000, fe_ready=1 -> r_eip=0000_2000, flush high for 2 cycles, then a 1-cycle fe_redirect, then RUN.
REQ-043 Same cycle exc_req (vector 32'h0000_0080), wb_redir_req (32'h0000_3000) and de_valid -> r_eip=0000_0080, exc_ack one cycle, wb and de ignored.
REQ-044 exc_req 32'h0000_00C0 in the 2nd FLUSH cycle -> r_eip=0000_00C0 and flush extended to 2 further cycles.
REQ-045 REFILL with fe_ready=0 for 5 cycles -> fe_redirect held 5 cycles, de_valid ignored, RUN after fe_ready.
REQ-046 rst asserted in REFILL -> next cycle RUN, r_eip=FFFF_FFF0, fe_redirect=0, and with the macro perf_redir_cnt=0.

Source files
------------

// File: rtl/eip_ctrl_pkg.sv
// Shared types and constants for the EIP redirect controller.
package eip_ctrl_pkg;

  localparam int unsigned FLUSH_CNT_W = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hFFFF_FFF0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_REFILL = 2'd2
  } eip_state_e;

endpackage

// File: rtl/eip_flush_timer.sv
// Loadable down-counter that times the FLUSH phase; done is high on the last flush cycle.
module eip_flush_timer
  import eip_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic [FLUSH_CNT_W-1:0] load_val_i,
  input  logic                   en_i,
  output logic                   done_o
);

  logic [FLUSH_CNT_W-1:0] cnt_q;
  logic [FLUSH_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of one means the current cycle is the final flush cycle.
  assign done_o = (cnt_q == FLUSH_CNT_W'(1));

endmodule

// File: rtl/eip_redirect_ctrl.sv
// Architectural EIP register with exception/writeback redirect, flush and fetch refill sequencing.
// Optional redirect performance counter enabled by macro EIP_REDIR_PERF_EN.
module eip_redirect_ctrl
  import eip_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de_valid,
  input  logic [31:0] de_eip_next,
  input  logic        wb_redir_req,
  input  logic [31:0] wb_redir_target,
  input  logic        exc_req,
  input  logic [31:0] exc_vector,
  input  logic        fe_ready,
  output logic [31:0] r_eip,
  output logic        flush,
  output logic        fe_redirect,
  output logic        exc_ack,
  output logic        busy,
`ifdef EIP_REDIR_PERF_EN
  output logic [15:0] perf_redir_cnt,
`endif
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_RUN    = ST_RUN;
  localparam logic [1:0] S_FLUSH  = ST_FLUSH;
  localparam logic [1:0] S_REFILL = ST_REFILL;
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [31:0] r_eip_q, r_eip_d;
  logic        flush_q, fe_redirect_q, busy_q;
  logic        exc_ack_q;
  logic        exc_take;
  logic        redir_take;
  logic        tmr_load, tmr_en, tmr_done;

  // Handshakes: exc_req is a level held by the source; exc_ack marks the single
  // accepting cycle. fe_redirect is held until a cycle with fe_ready high.
  // The registered ack blocks a second acceptance of a still-held request.
  assign exc_take = exc_req & ~rst & ~exc_ack_q;
  assign exc_ack  = exc_take;

  always_comb begin
    state_d    = state_q;
    r_eip_d    = r_eip_q;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    redir_take = 1'b0;
    case (state_q)
      S_RUN: begin
        if (exc_take) begin
          r_eip_d    = exc_vector;
          state_d    = S_FLUSH;
          tmr_load   = 1'b1;
          redir_take = 1'b1;
        end else if (wb_redir_req) begin
          r_eip_d    = wb_redir_target;
          state_d    = S_FLUSH;
          tmr_load   = 1'b1;
          redir_take = 1'b1;
        end else if (de_valid) begin
          r_eip_d = de_eip_next;
        end
      end
      S_FLUSH: begin
        if (exc_take) begin
          r_eip_d    = exc_vector;
          tmr_load   = 1'b1;
          redir_take = 1'b1;
        end else begin
          tmr_en = 1'b1;
          if (tmr_done) state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (exc_take) begin
          r_eip_d    = exc_vector;
          state_d    = S_FLUSH;
          tmr_load   = 1'b1;
          redir_take = 1'b1;
        end else if (fe_ready) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  eip_flush_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (FLUSH_LOAD),
    .en_i       (tmr_en),
    .done_o     (tmr_done)
  );

  // Outputs are registered decodes of the next state, so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RUN;
      r_eip_q       <= RESET_VECTOR;
      flush_q       <= 1'b0;
      fe_redirect_q <= 1'b0;
      busy_q        <= 1'b0;
      exc_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      r_eip_q       <= r_eip_d;
      flush_q       <= (state_d == S_FLUSH);
      fe_redirect_q <= (state_d == S_REFILL);
      busy_q        <= (state_d != S_RUN);
      exc_ack_q     <= exc_take;
    end
  end

`ifdef EIP_REDIR_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (redir_take && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_redir_cnt = perf_q;
`else
  logic unused_redir_take;
  assign unused_redir_take = redir_take;
`endif

  assign r_eip       = r_eip_q;
  assign flush       = flush_q;
  assign fe_redirect = fe_redirect_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_eip_redirect_ctrl.sv
// Directed self-checking bench for eip_redirect_ctrl (default FLUSH_CYCLES=2).
module tb_eip_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic        de_valid;
  logic [31:0] de_eip_next;
  logic        wb_redir_req;
  logic [31:0] wb_redir_target;
  logic        exc_req;
  logic [31:0] exc_vector;
  logic        fe_ready;
  logic [31:0] r_eip;
  logic        flush;
  logic        fe_redirect;
  logic        exc_ack;
  logic        busy;
  logic [1:0]  dbg_state;
`ifdef EIP_REDIR_PERF_EN
  logic [15:0] perf_redir_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  eip_redirect_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .de_valid        (de_valid),
    .de_eip_next     (de_eip_next),
    .wb_redir_req    (wb_redir_req),
    .wb_redir_target (wb_redir_target),
    .exc_req         (exc_req),
    .exc_vector      (exc_vector),
    .fe_ready        (fe_ready),
    .r_eip           (r_eip),
    .flush           (flush),
    .fe_redirect     (fe_redirect),
    .exc_ack         (exc_ack),
    .busy            (busy),
`ifdef EIP_REDIR_PERF_EN
    .perf_redir_cnt  (perf_redir_cnt),
`endif
    .dbg_state       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] eip, input logic fl,
                            input logic fr, input logic bz);
    check_eq({tag, ".r_eip"}, r_eip, eip);
    check_eq({tag, ".flush"}, 32'(flush), 32'(fl));
    check_eq({tag, ".fe_redirect"}, 32'(fe_redirect), 32'(fr));
    check_eq({tag, ".busy"}, 32'(busy), 32'(bz));
  endtask

  initial begin
    rst = 1'b1; de_valid = 1'b0; de_eip_next = '0; wb_redir_req = 1'b0;
    wb_redir_target = '0; exc_req = 1'b0; exc_vector = '0; fe_ready = 1'b0;
    step();
    step();

    // reset state and ack masking under reset
    check_outs("reset", 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);
    check_eq("reset.state", 32'(dbg_state), 32'd0);
    exc_req = 1'b1; #1;
    check_eq("reset.exc_ack", 32'(exc_ack), 32'd0);
    exc_req = 1'b0;

    // sequential advance
    rst = 1'b0; de_valid = 1'b1; de_eip_next = 32'h0000_1004;
    step();
    check_outs("seq", 32'h0000_1004, 1'b0, 1'b0, 1'b0);
    de_valid = 1'b0;
    step();
    check_eq("seq.hold", r_eip, 32'h0000_1004);

    // writeback redirect with fetch ready at refill entry
    wb_redir_req = 1'b1; wb_redir_target = 32'h0000_2000; fe_ready = 1'b1;
    step();
    wb_redir_req = 1'b0;
    check_outs("wb.f1", 32'h0000_2000, 1'b1, 1'b0, 1'b1);
    step();
    check_outs("wb.f2", 32'h0000_2000, 1'b1, 1'b0, 1'b1);
    step();
    check_outs("wb.refill", 32'h0000_2000, 1'b0, 1'b1, 1'b1);
    step();
    check_outs("wb.run", 32'h0000_2000, 1'b0, 1'b0, 1'b0);

    // simultaneous exc, wb and de: exception wins
    exc_req = 1'b1; exc_vector = 32'h0000_0080;
    wb_redir_req = 1'b1; wb_redir_target = 32'h0000_3000;
    de_valid = 1'b1; de_eip_next = 32'h0000_5555;
    #1;
    check_eq("prio.ack", 32'(exc_ack), 32'd1);
    step();
    check_outs("prio.f1", 32'h0000_0080, 1'b1, 1'b0, 1'b1);
    check_eq("prio.ack_once", 32'(exc_ack), 32'd0);
    exc_req = 1'b0;
    step();
    check_outs("prio.f2", 32'h0000_0080, 1'b1, 1'b0, 1'b1);
    wb_redir_req = 1'b0; de_valid = 1'b0;
    step();
    check_outs("prio.refill", 32'h0000_0080, 1'b0, 1'b1, 1'b1);
    step();
    check_eq("prio.run", 32'(dbg_state), 32'd0);

    // exception in second flush cycle restarts the flush
    wb_redir_req = 1'b1; wb_redir_target = 32'h0000_4000;
    step();
    wb_redir_req = 1'b0;
    step();
    check_outs("restart.f2", 32'h0000_4000, 1'b1, 1'b0, 1'b1);
    exc_req = 1'b1; exc_vector = 32'h0000_00C0; #1;
    check_eq("restart.ack", 32'(exc_ack), 32'd1);
    step();
    exc_req = 1'b0;
    check_outs("restart.fa", 32'h0000_00C0, 1'b1, 1'b0, 1'b1);
    step();
    check_outs("restart.fb", 32'h0000_00C0, 1'b1, 1'b0, 1'b1);
    step();
    check_outs("restart.refill", 32'h0000_00C0, 1'b0, 1'b1, 1'b1);
    step();
    check_outs("restart.run", 32'h0000_00C0, 1'b0, 1'b0, 1'b0);

    // refill stall: fe_ready low, de_valid ignored
    fe_ready = 1'b0;
    wb_redir_req = 1'b1; wb_redir_target = 32'h0000_6000;
    step();
    wb_redir_req = 1'b0;
    step();
    step();
    de_valid = 1'b1; de_eip_next = 32'h0000_7777;
    check_outs("stall.c1", 32'h0000_6000, 1'b0, 1'b1, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      step();
      check_outs($sformatf("stall.c%0d", i), 32'h0000_6000, 1'b0, 1'b1, 1'b1);
    end
    fe_ready = 1'b1;
    step();
    check_outs("stall.run", 32'h0000_6000, 1'b0, 1'b0, 1'b0);
    de_valid = 1'b0;

    // reset abandons a refill in progress
    fe_ready = 1'b0;
    wb_redir_req = 1'b1; wb_redir_target = 32'h0000_8000;
    step();
    wb_redir_req = 1'b0;
    step();
    step();
    check_outs("rstref.refill", 32'h0000_8000, 1'b0, 1'b1, 1'b1);
`ifdef EIP_REDIR_PERF_EN
    check_eq("perf.count", 32'(perf_redir_cnt), 32'd6);
`endif
    rst = 1'b1;
    step();
    check_outs("rstref.rst", 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);
    check_eq("rstref.state", 32'(dbg_state), 32'd0);
`ifdef EIP_REDIR_PERF_EN
    check_eq("perf.reset", 32'(perf_redir_cnt), 32'd0);
`endif
    rst = 1'b0;
    step();
    check_outs("rstref.after", 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
